// File: rtl/xor_chk_pkg.sv
// Shared definitions for the XOR gate pattern checker: FSM encoding,
// sweep length and counter widths.
package xor_chk_pkg;

    // Checker control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A full sweep covers every two-input combination once.
    localparam int NUM_VECTORS = 4;
    localparam int VEC_IDX_W   = $clog2(NUM_VECTORS);

    // Wide enough to count every vector of a sweep as failing (0..4).
    localparam int ERR_CNT_W   = 3;

endpackage : xor_chk_pkg

// File: rtl/xor_pattern_checker.sv
// Exhaustive pattern checker for a two-input XOR gate. On start it drives
// the vectors 00, 01, 10, 11, holding each for HOLD_CYCLES clocks, samples
// the gate's sum on the last hold cycle of each vector, and reports the
// mismatch count, the first failing vector and an overall pass flag.
module xor_pattern_checker
    import xor_chk_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dut_sum,
    output logic                 in_a,
    output logic                 in_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           first_fail_idx
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [HOLD_W-1:0]    LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VEC_IDX_W-1:0] LAST_VEC  = VEC_IDX_W'(NUM_VECTORS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [VEC_IDX_W-1:0]   vec_idx;
    logic [VEC_IDX_W-1:0]   vec_idx_next;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HOLD_W-1:0]      hold_cnt_next;
    logic [ERR_CNT_W-1:0]   err_cnt_next;
    logic [1:0]             first_fail_idx_next;
    logic                   in_a_next;
    logic                   in_b_next;
    logic                   mismatch;

    // The gate is expected to return the XOR of the operands currently applied.
    assign mismatch = dut_sum != (in_a ^ in_b);

    // Next-state, counter and operand logic for the sweep.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next          = state;
        vec_idx_next        = vec_idx;
        hold_cnt_next       = hold_cnt;
        err_cnt_next        = err_cnt;
        first_fail_idx_next = first_fail_idx;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next          = ST_DRIVE;
                    vec_idx_next        = '0;
                    hold_cnt_next       = '0;
                    err_cnt_next        = '0;
                    first_fail_idx_next = '0;
                end
            end

            ST_DRIVE: begin
                // start is deliberately not looked at here: a sweep runs to completion.
                if (hold_cnt == LAST_HOLD) begin
                    if (mismatch) begin
                        err_cnt_next = err_cnt + ERR_CNT_W'(1);
                        if (err_cnt == '0) begin
                            first_fail_idx_next = vec_idx;
                        end
                    end
                    hold_cnt_next = '0;
                    if (vec_idx == LAST_VEC) begin
                        state_next = ST_DONE;
                    end else begin
                        vec_idx_next = vec_idx + VEC_IDX_W'(1);
                    end
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Operands follow the vector that will be active next cycle, so they
        // change on the same edge as vec_idx and are zero outside a sweep.
        in_a_next = (state_next == ST_DRIVE) ? vec_idx_next[1] : 1'b0;
        in_b_next = (state_next == ST_DRIVE) ? vec_idx_next[0] : 1'b0;
    end

    // State, counters and operand registers; reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vec_idx        <= '0;
            hold_cnt       <= '0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
            in_a           <= 1'b0;
            in_b           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state          <= state_next;
            vec_idx        <= vec_idx_next;
            hold_cnt       <= hold_cnt_next;
            err_cnt        <= err_cnt_next;
            first_fail_idx <= first_fail_idx_next;
            in_a           <= in_a_next;
            in_b           <= in_b_next;
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        busy = (state == ST_DRIVE);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_cnt == '0);
    end

endmodule : xor_pattern_checker

// File: tb/tb_xor_pattern_checker.sv
// Directed bench for xor_pattern_checker: two instances (HOLD_CYCLES 5 and 2)
// each driven by a configurable model of the gate under test.
module tb_xor_pattern_checker;

    typedef enum int { GATE_GOOD, GATE_ZERO, GATE_INV, GATE_ONE } gate_mode_t;

    logic clk;
    logic rst_n;
    logic start;
    logic sel;        // 0: observe the HOLD=5 instance, 1: the HOLD=2 instance
    int   cur_hold;
    gate_mode_t mode;

    logic       start5, sum5, a5, b5, busy5, done5, pass5;
    logic [2:0] err5;
    logic [1:0] ffi5;
    logic       start2, sum2, a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] ffi2;

    logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
    logic [2:0] obs_err;
    logic [1:0] obs_ffi;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles;
    logic [1:0] seen [4];

    function automatic logic gate_model(input gate_mode_t m, input logic a, input logic b);
        case (m)
            GATE_GOOD: return a ^ b;
            GATE_ZERO: return 1'b0;
            GATE_INV:  return ~(a ^ b);
            default:   return 1'b1;
        endcase
    endfunction

    assign sum5   = gate_model(mode, a5, b5);
    assign sum2   = gate_model(mode, a2, b2);
    assign start5 = sel ? 1'b0 : start;
    assign start2 = sel ? start : 1'b0;

    assign obs_a    = sel ? a2    : a5;
    assign obs_b    = sel ? b2    : b5;
    assign obs_busy = sel ? busy2 : busy5;
    assign obs_done = sel ? done2 : done5;
    assign obs_pass = sel ? pass2 : pass5;
    assign obs_err  = sel ? err2  : err5;
    assign obs_ffi  = sel ? ffi2  : ffi5;

    xor_pattern_checker #(.HOLD_CYCLES(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .dut_sum(sum5),
        .in_a(a5), .in_b(b5), .busy(busy5), .done(done5), .pass(pass5),
        .err_cnt(err5), .first_fail_idx(ffi5)
    );

    xor_pattern_checker #(.HOLD_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_sum(sum2),
        .in_a(a2), .in_b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_fail_idx(ffi2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 8'(obs_busy), 8'd0);
        check({tag, "_done"}, 8'(obs_done), 8'd0);
        check({tag, "_pass"}, 8'(obs_pass), 8'd0);
        check({tag, "_err"},  8'(obs_err),  8'd0);
        check({tag, "_ffi"},  8'(obs_ffi),  8'd0);
        check({tag, "_ab"},   8'({obs_a, obs_b}), 8'd0);
    endtask

    // Pulse start for one clock, then count busy clocks (sampled on falling
    // edges). Optionally re-pulse start or assert reset at a given busy clock.
    task automatic run_sweep(input int repulse_at, input int reset_at);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 4; k++) seen[k] = 2'bxx;
        while (obs_busy && busy_cycles < 200) begin
            busy_cycles++;
            if ((busy_cycles - 1) % cur_hold == 0 && (busy_cycles - 1) / cur_hold < 4)
                seen[(busy_cycles - 1) / cur_hold] = {obs_a, obs_b};
            if (busy_cycles == 1) begin
                check("first_busy_err_clear", 8'(obs_err),  8'd0);
                check("first_busy_done_low",  8'(obs_done), 8'd0);
                check("first_busy_pass_low",  8'(obs_pass), 8'd0);
            end
            start = (busy_cycles == repulse_at);
            if (busy_cycles == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("async_reset");
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_busy, input logic [2:0] exp_err,
                                input logic [1:0] exp_ffi, input logic exp_pass);
        check({tag, "_busy_clocks"}, 8'(busy_cycles), 8'(exp_busy));
        check({tag, "_done"},        8'(obs_done),    8'd1);
        check({tag, "_pass"},        8'(obs_pass),    8'(exp_pass));
        check({tag, "_err_cnt"},     8'(obs_err),     8'(exp_err));
        check({tag, "_ffi"},         8'(obs_ffi),     8'(exp_ffi));
        check({tag, "_ab_idle"},     8'({obs_a, obs_b}), 8'd0);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_vec%0d", tag, k), 8'(seen[k]), 8'(k));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        cur_hold = 5;
        mode     = GATE_GOOD;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("idle_after_reset");

        // Good gate: 20 busy clocks, pass.
        run_sweep(-1, -1);
        check_result("good", 20, 3'd0, 2'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("done_held", 8'(obs_done), 8'd1);

        // Sum stuck at 0: vectors 01 and 10 fail.
        mode = GATE_ZERO;
        run_sweep(-1, -1);
        check_result("stuck0", 20, 3'd2, 2'd1, 1'b0);

        // Inverted gate: every vector fails, first at index 0.
        mode = GATE_INV;
        run_sweep(-1, -1);
        check_result("inverted", 20, 3'd4, 2'd0, 1'b0);

        // start re-pulsed at busy clock 7 is ignored.
        mode = GATE_GOOD;
        run_sweep(7, -1);
        check_result("repulse", 20, 3'd0, 2'd0, 1'b1);

        // Reset at busy clock 12 of a failing sweep, then a clean sweep.
        mode = GATE_ZERO;
        run_sweep(-1, 12);
        repeat (4) @(negedge clk);
        check_all_zero("idle_after_midreset");
        mode = GATE_GOOD;
        run_sweep(-1, -1);
        check_result("after_reset", 20, 3'd0, 2'd0, 1'b1);

        // HOLD_CYCLES=2 instance, sum stuck at 1: vectors 00 and 11 fail.
        sel      = 1'b1;
        cur_hold = 2;
        mode     = GATE_ONE;
        run_sweep(-1, -1);
        check_result("h2_stuck1", 8, 3'd2, 2'd0, 1'b0);

        // Restart from DONE with a good gate: counters clear, sweep reruns.
        mode = GATE_GOOD;
        run_sweep(-1, -1);
        check_result("h2_rerun", 8, 3'd0, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_xor_pattern_checker
